// File: rtl/regfile_dump_reader.sv
// Register file dump reader: walks first..last through one read port
// and streams (index, data) beats on a valid/ready interface.
module regfile_dump_reader #(
  parameter int READ_LATENCY = 1,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  input  logic        abort,
  output logic [4:0]  rd_reg,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [1:0] LAT    = 2'(READ_LATENCY);
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);
  localparam logic [4:0] MAX_IX = 5'(NUM_REGS - 1);

  state_t      r_state;
  logic [4:0]  r_cur;
  logic [4:0]  r_last;
  logic [1:0]  r_cnt;
  logic [4:0]  r_rd_reg;
  logic        r_out_valid;
  logic [4:0]  r_out_index;
  logic [31:0] r_out_data;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  w_last;

  assign w_last = (last_reg > MAX_IX) ? MAX_IX : last_reg;

  // After a handshake rd_reg has been settling since the accept edge,
  // so the reload is one shorter than the initial load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_rd_reg    <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (first_reg <= w_last) begin
              r_cur    <= first_reg;
              r_last   <= w_last;
              r_rd_reg <= first_reg;
              r_cnt    <= LAT;
              r_busy   <= 1'b1;
              r_state  <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == 2'd0) begin
            r_out_data  <= rd_data;
            r_out_index <= r_cur;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_cur == r_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur    <= r_cur + 5'd1;
              r_rd_reg <= r_cur + 5'd1;
              r_cnt    <= LAT_M1;
              r_state  <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_reg    = r_rd_reg;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump requests, scoreboard
// queue of expected beats, plus reset and abort sequences.
module tb_regfile_dump_reader;

  localparam int RL = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        abort;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  int          cyc;
  int          errors;
  int          checks;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         sb;
    int         sl;
    int         ab;
    int         bb;
    int         lat;
  } vec_t;

  beat_t q[$];
  vec_t  tv[7];

  regfile_dump_reader #(.READ_LATENCY(RL), .NUM_REGS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = regs[rd_reg];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic run(input vec_t v);
    int    n;
    int    beat;
    int    scnt;
    int    lat;
    int    t0;
    bit    seen_v;
    bit    any_busy;
    bit    sbd;
    beat_t b;
    n = (v.f <= v.l) ? int'(v.l) - int'(v.f) + 1 : 0;
    for (int i = 0; i < n; i++) begin
      if (v.ab < 0 || i < v.ab) begin
        b.idx = 5'(int'(v.f) + i);
        b.d   = regs[int'(v.f) + i];
        q.push_back(b);
      end
    end
    first_reg = v.f;
    last_reg  = v.l;
    out_ready = 1'b1;
    start     = 1'b1;
    t0        = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    first_reg = 5'd3;
    last_reg  = 5'd1;
    beat = 0; scnt = 0; lat = -1;
    seen_v = 0; any_busy = 0; sbd = 0;
    for (int k = 0; k < 300; k++) begin
      start = 1'b0;
      if (busy) any_busy = 1;
      if (done) begin
        lat = cyc - t0;
        break;
      end
      if (out_valid && !seen_v) begin
        seen_v = 1;
        chk("first_valid_lat", cyc - t0, RL + 1);
      end
      if (out_valid && beat == v.ab) begin
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (4) begin
          @(negedge clk);
          if (done) lat = cyc - t0;
        end
        break;
      end
      if (out_valid && beat == v.sb && scnt < v.sl) begin
        out_ready = 1'b0;
        scnt++;
        if (q.size() > 0) chk("stall_hold", {out_index, out_data}, q[0]);
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            b = q.pop_front();
            chk("beat", {out_index, out_data}, b);
          end
          beat++;
          if (beat == v.bb && !sbd) begin
            start     = 1'b1;
            first_reg = 5'd0;
            last_reg  = 5'd0;
            sbd       = 1;
          end
        end
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_lat", lat, v.lat);
    chk("queue_empty", q.size(), 0);
    chk("beat_count", beat, (v.ab < 0) ? n : v.ab);
    chk("busy_seen", any_busy, (n > 0) ? 1 : 0);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_after", busy, 0);
    q.delete();
  endtask

  initial begin
    bit got_v;
    errors = 0; checks = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_reg = '0; last_reg = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);
    regs[8]  = 10; regs[9]  = 20; regs[10] = 22; regs[11] = 40;
    regs[12] = 50; regs[13] = 60; regs[14] = 70; regs[15] = 80;
    regs[16] = 1;  regs[17] = 2;  regs[18] = 0;  regs[31] = 0;

    tv[0] = '{f:8,  l:15, sb:-1, sl:0, ab:-1, bb:-1, lat:17};
    tv[1] = '{f:8,  l:15, sb:2,  sl:5, ab:-1, bb:-1, lat:22};
    tv[2] = '{f:20, l:19, sb:-1, sl:0, ab:-1, bb:-1, lat:0};
    tv[3] = '{f:31, l:31, sb:-1, sl:0, ab:-1, bb:-1, lat:3};
    tv[4] = '{f:16, l:23, sb:-1, sl:0, ab:2,  bb:-1, lat:-1};
    tv[5] = '{f:16, l:17, sb:-1, sl:0, ab:-1, bb:-1, lat:5};
    tv[6] = '{f:8,  l:15, sb:-1, sl:0, ab:-1, bb:3,  lat:17};

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_reg", rd_reg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run(tv[i]);

    first_reg = 5'd8;
    last_reg  = 5'd15;
    out_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_v = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        got_v = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_valid_seen", got_v, 1);
    chk("rst_mid_index", out_index, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_index", out_index, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_rd_reg", rd_reg, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    run(tv[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
